// File: rtl/wired_ftq_upd_arb.sv
// Update-port arbiter for wired_ftq: per-source FIFOs, one strict-priority source,
// round-robin among the rest, grant lock while the FTQ back-pressures, non-priority flush.
module wired_ftq_upd_arb #(
    parameter int unsigned N_SRC      = 3,
    parameter int unsigned UPD_W      = 96,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned PRIO_SRC   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SRC-1:0]         src_valid_i,
    output logic [N_SRC-1:0]         src_ready_o,
    input  logic [N_SRC*UPD_W-1:0]   src_upd_i,
    input  logic                     flush_i,
    output logic                     upd_valid_o,
    input  logic                     upd_ready_i,
    output logic [UPD_W-1:0]         upd_req_o,
    output logic [$clog2(N_SRC)-1:0] upd_src_o,
    output logic                     busy_o
);
    localparam int unsigned SRC_W = $clog2(N_SRC);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [UPD_W-1:0] mem_q    [N_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [N_SRC];
    logic [PTR_W-1:0] wr_ptr_d [N_SRC];
    logic [PTR_W-1:0] rd_ptr_q [N_SRC];
    logic [PTR_W-1:0] rd_ptr_d [N_SRC];
    logic [CNT_W-1:0] count_q  [N_SRC];
    logic [CNT_W-1:0] count_d  [N_SRC];
    logic [N_SRC-1:0] ready_q, ready_d;
    logic [N_SRC-1:0] push_c, pop_c;
    logic             busy_q, busy_d;
    logic             lock_q, lock_d;
    logic [SRC_W-1:0] lock_src_q, lock_src_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [UPD_W-1:0] req_last_q, req_last_d;
    logic [SRC_W-1:0] src_last_q, src_last_d;
    logic [SRC_W-1:0] gnt_c;
    logic [UPD_W-1:0] head_c;
    logic             hs_c;
    logic             found_c;
    int               idx_c;

    // Grant select: held lock, then priority source, then round-robin from rr_ptr.
    always_comb begin
        gnt_c   = SRC_W'(PRIO_SRC);
        found_c = 1'b0;
        idx_c   = 0;
        if (lock_q) begin
            gnt_c = lock_src_q;
        end else if (count_q[PRIO_SRC] != '0) begin
            gnt_c = SRC_W'(PRIO_SRC);
        end else begin
            for (int k = 0; k < int'(N_SRC); k++) begin
                idx_c = (int'(rr_ptr_q) + k) % int'(N_SRC);
                if (!found_c && idx_c != int'(PRIO_SRC) && count_q[idx_c] != '0) begin
                    found_c = 1'b1;
                    gnt_c   = SRC_W'(idx_c);
                end
            end
        end
    end

    assign head_c      = mem_q[gnt_c][rd_ptr_q[gnt_c]];
    assign upd_valid_o = (count_q[gnt_c] != '0);
    assign hs_c        = upd_valid_o & upd_ready_i;
    assign upd_req_o   = upd_valid_o ? head_c : req_last_q;
    assign upd_src_o   = upd_valid_o ? gnt_c  : src_last_q;
    assign src_ready_o = ready_q;
    assign busy_o      = busy_q;

    // FIFO bookkeeping; flush wipes every non-priority FIFO including its in-cycle push.
    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            push_c[i]   = src_valid_i[i] & ready_q[i] & ~(flush_i & (i != int'(PRIO_SRC)));
            pop_c[i]    = hs_c & (gnt_c == SRC_W'(i));
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            if (flush_i && i != int'(PRIO_SRC)) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end else begin
                if (push_c[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
                if (pop_c[i])  rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
                count_d[i] = count_q[i] + CNT_W'(push_c[i]) - CNT_W'(pop_c[i]);
            end
            ready_d[i] = (count_d[i] != CNT_W'(FIFO_DEPTH));
            busy_d     = busy_d | (count_d[i] != '0);
        end
    end

    // Lock, round-robin pointer and output hold registers.
    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        rr_ptr_d   = rr_ptr_q;
        req_last_d = req_last_q;
        src_last_d = src_last_q;
        if (hs_c) begin
            lock_d = 1'b0;
            if (gnt_c != SRC_W'(PRIO_SRC))
                rr_ptr_d = (gnt_c == SRC_W'(N_SRC - 1)) ? '0 : gnt_c + SRC_W'(1);
        end else if (upd_valid_o) begin
            lock_d     = 1'b1;
            lock_src_d = gnt_c;
        end
        if (flush_i && lock_src_d != SRC_W'(PRIO_SRC))
            lock_d = 1'b0;
        if (upd_valid_o) begin
            req_last_d = head_c;
            src_last_d = gnt_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            ready_q    <= '1;
            busy_q     <= 1'b0;
            lock_q     <= 1'b0;
            lock_src_q <= '0;
            rr_ptr_q   <= '0;
            req_last_q <= '0;
            src_last_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            rr_ptr_q   <= rr_ptr_d;
            req_last_q <= req_last_d;
            src_last_q <= src_last_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(N_SRC); i++)
            if (push_c[i]) mem_q[i][wr_ptr_q[i]] <= src_upd_i[i*int'(UPD_W) +: int'(UPD_W)];
    end

endmodule

// File: tb/tb_wired_ftq_upd_arb.sv
// Directed table-driven bench for wired_ftq_upd_arb, plus an async-reset sequence.
module tb_wired_ftq_upd_arb;
    localparam int unsigned N_SRC = 3;
    localparam int unsigned UPD_W = 96;

    logic               clk;
    logic               rst_n;
    logic [N_SRC-1:0]   src_valid_i;
    logic [N_SRC-1:0]   src_ready_o;
    logic [N_SRC*UPD_W-1:0] src_upd_i;
    logic               flush_i;
    logic               upd_valid_o;
    logic               upd_ready_i;
    logic [UPD_W-1:0]   upd_req_o;
    logic [1:0]         upd_src_o;
    logic               busy_o;

    int checks;
    int failures;

    typedef struct {
        logic [2:0]  v;
        logic [31:0] d0, d1, d2;
        logic        rdy;
        logic        fl;
        logic        e_v;
        logic [1:0]  e_src;
        logic [31:0] e_req;
        logic [2:0]  e_srdy;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    wired_ftq_upd_arb #(.N_SRC(N_SRC), .UPD_W(UPD_W), .FIFO_DEPTH(2), .PRIO_SRC(0)) dut (
        .clk(clk), .rst_n(rst_n), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
        .src_upd_i(src_upd_i), .flush_i(flush_i), .upd_valid_o(upd_valid_o),
        .upd_ready_i(upd_ready_i), .upd_req_o(upd_req_o), .upd_src_o(upd_src_o),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic [2:0] v, logic [31:0] d0, logic [31:0] d1,
                                logic [31:0] d2, logic rdy, logic fl, logic e_v,
                                logic [1:0] e_src, logic [31:0] e_req,
                                logic [2:0] e_srdy, logic e_busy);
        vec_t r;
        r.v = v; r.d0 = d0; r.d1 = d1; r.d2 = d2; r.rdy = rdy; r.fl = fl;
        r.e_v = e_v; r.e_src = e_src; r.e_req = e_req; r.e_srdy = e_srdy; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic chk(input string name, input int step, input logic [95:0] got,
                       input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h exp=%h", name, step, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic rdy, input logic fl);
        src_valid_i = v;
        src_upd_i   = {64'h0, d2, 64'h0, d1, 64'h0, d0};
        upd_ready_i = rdy;
        flush_i     = fl;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        drive(3'b000, 0, 0, 0, 1'b0, 1'b0);

        //          v       d0     d1     d2     rdy fl  e_v e_src e_req  e_srdy e_busy
        tbl.push_back(mk(3'b010, 0,     'hA1,  0,     1, 0,  0, 0, 0,     3'b111, 0)); // 0 reset
        tbl.push_back(mk(3'b000, 0,     0,     0,     1, 0,  1, 1, 'hA1,  3'b111, 1)); // 1
        tbl.push_back(mk(3'b100, 0,     0,     'hD0,  1, 0,  0, 1, 'hA1,  3'b111, 0)); // 2
        tbl.push_back(mk(3'b000, 0,     0,     0,     1, 0,  1, 2, 'hD0,  3'b111, 1)); // 3
        tbl.push_back(mk(3'b110, 0,     'hB1,  'hC1,  0, 0,  0, 2, 'hD0,  3'b111, 0)); // 4
        tbl.push_back(mk(3'b110, 0,     'hB2,  'hC2,  0, 0,  1, 1, 'hB1,  3'b111, 1)); // 5
        tbl.push_back(mk(3'b000, 0,     0,     0,     1, 0,  1, 1, 'hB1,  3'b001, 1)); // 6
        tbl.push_back(mk(3'b000, 0,     0,     0,     1, 0,  1, 2, 'hC1,  3'b011, 1)); // 7
        tbl.push_back(mk(3'b000, 0,     0,     0,     1, 0,  1, 1, 'hB2,  3'b111, 1)); // 8
        tbl.push_back(mk(3'b000, 0,     0,     0,     1, 0,  1, 2, 'hC2,  3'b111, 1)); // 9
        tbl.push_back(mk(3'b010, 0,     'hE1,  0,     0, 0,  0, 2, 'hC2,  3'b111, 0)); // 10
        tbl.push_back(mk(3'b001, 'hF0,  0,     0,     0, 0,  1, 1, 'hE1,  3'b111, 1)); // 11
        tbl.push_back(mk(3'b000, 0,     0,     0,     0, 0,  1, 1, 'hE1,  3'b111, 1)); // 12
        tbl.push_back(mk(3'b000, 0,     0,     0,     1, 0,  1, 1, 'hE1,  3'b111, 1)); // 13
        tbl.push_back(mk(3'b000, 0,     0,     0,     1, 0,  1, 0, 'hF0,  3'b111, 1)); // 14
        tbl.push_back(mk(3'b110, 0,     'h11,  'h12,  0, 0,  0, 0, 'hF0,  3'b111, 0)); // 15
        tbl.push_back(mk(3'b000, 0,     0,     0,     1, 0,  1, 2, 'h12,  3'b111, 1)); // 16
        tbl.push_back(mk(3'b000, 0,     0,     0,     1, 0,  1, 1, 'h11,  3'b111, 1)); // 17
        tbl.push_back(mk(3'b100, 0,     0,     'h61,  0, 0,  0, 1, 'h11,  3'b111, 0)); // 18
        tbl.push_back(mk(3'b100, 0,     0,     'h62,  0, 0,  1, 2, 'h61,  3'b111, 1)); // 19
        tbl.push_back(mk(3'b100, 0,     0,     'h63,  1, 0,  1, 2, 'h61,  3'b011, 1)); // 20
        tbl.push_back(mk(3'b000, 0,     0,     0,     1, 0,  1, 2, 'h62,  3'b111, 1)); // 21
        tbl.push_back(mk(3'b111, 'h50,  'hB5,  'hC5,  0, 0,  0, 2, 'h62,  3'b111, 0)); // 22
        tbl.push_back(mk(3'b000, 0,     0,     0,     0, 1,  1, 0, 'h50,  3'b111, 1)); // 23
        tbl.push_back(mk(3'b000, 0,     0,     0,     1, 0,  1, 0, 'h50,  3'b111, 1)); // 24
        tbl.push_back(mk(3'b010, 0,     'h77,  0,     0, 0,  0, 0, 'h50,  3'b111, 0)); // 25
        tbl.push_back(mk(3'b000, 0,     0,     0,     0, 1,  1, 1, 'h77,  3'b111, 1)); // 26
        tbl.push_back(mk(3'b100, 0,     0,     'h88,  1, 1,  0, 1, 'h77,  3'b111, 0)); // 27
        tbl.push_back(mk(3'b000, 0,     0,     0,     1, 0,  0, 1, 'h77,  3'b111, 0)); // 28

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[s]) begin
            @(negedge clk);
            chk("upd_valid", s, 96'(upd_valid_o), 96'(tbl[s].e_v));
            chk("upd_src",   s, 96'(upd_src_o),   96'(tbl[s].e_src));
            chk("upd_req",   s, upd_req_o,        96'(tbl[s].e_req));
            chk("src_ready", s, 96'(src_ready_o), 96'(tbl[s].e_srdy));
            chk("busy",      s, 96'(busy_o),      96'(tbl[s].e_busy));
            drive(tbl[s].v, tbl[s].d0, tbl[s].d1, tbl[s].d2, tbl[s].rdy, tbl[s].fl);
        end

        // Asynchronous reset with all FIFOs partly full.
        @(negedge clk);
        drive(3'b111, 'h31, 'h32, 'h33, 1'b0, 1'b0);
        @(negedge clk);
        drive(3'b010, 0, 'h34, 0, 1'b0, 1'b0);
        @(negedge clk);
        drive(3'b000, 0, 0, 0, 1'b0, 1'b0);
        chk("pre_rst_valid", 100, 96'(upd_valid_o), 96'(1));
        chk("pre_rst_req",   100, upd_req_o,        96'('h31));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 101, 96'(upd_valid_o), 96'(0));
        chk("rst_req",   101, upd_req_o,        96'(0));
        chk("rst_src",   101, 96'(upd_src_o),   96'(0));
        chk("rst_ready", 101, 96'(src_ready_o), 96'(3'b111));
        chk("rst_busy",  101, 96'(busy_o),      96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        upd_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_valid", 102 + c, 96'(upd_valid_o), 96'(0));
            chk("post_rst_busy",  102 + c, 96'(busy_o),      96'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
